// File: rtl/serial_link_tx_arbiter_pkg.sv
// Shared frame geometry and TL message types for the chip-to-chip serial link.
// The receive-side deserializer imports the same offsets so both ends agree beat for beat.
package serial_link_pkg;

    localparam int FRAME_W = 192;
    localparam int BEAT_W  = 32;
    localparam int BEATS   = 6;

    localparam int UNION_LSB   = 1;
    localparam int UNION_W     = 9;
    localparam int CORRUPT_LSB = 10;
    localparam int DATA_LSB    = 11;
    localparam int DATA_W      = 64;
    localparam int ADDR_LSB    = 75;
    localparam int ADDR_W      = 64;
    localparam int SOURCE_LSB  = 139;
    localparam int SOURCE_W    = 8;
    localparam int SIZE_LSB    = 147;
    localparam int SIZE_W      = 8;
    localparam int PARAM_LSB   = 155;
    localparam int PARAM_W     = 3;
    localparam int OPCODE_LSB  = 158;
    localparam int OPCODE_W    = 3;
    localparam int CHAN_LSB    = 161;
    localparam int CHAN_W      = 3;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [PARAM_W-1:0]  param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
        logic [UNION_W-1:0]  tl_union;
    } tl_msg_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Unused frame bits (bit 0 and the top pad) are transmitted as zero.
    function automatic logic [FRAME_W-1:0] pack_frame(input tl_msg_t msg, input logic [CHAN_W-1:0] chan);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[UNION_LSB  +: UNION_W]  = msg.tl_union;
        f[CORRUPT_LSB]            = msg.corrupt;
        f[DATA_LSB   +: DATA_W]   = msg.data;
        f[ADDR_LSB   +: ADDR_W]   = msg.address;
        f[SOURCE_LSB +: SOURCE_W] = msg.source;
        f[SIZE_LSB   +: SIZE_W]   = msg.size;
        f[PARAM_LSB  +: PARAM_W]  = msg.param;
        f[OPCODE_LSB +: OPCODE_W] = msg.opcode;
        f[CHAN_LSB   +: CHAN_W]   = chan;
        return f;
    endfunction

endpackage

// File: rtl/serial_link_tx_arbiter_if.sv
// Requester-side and link-side signals of the serial link transmit arbiter.
interface serial_link_tx_arbiter_if #(
    parameter int NUM_CHAN = 5
);
    logic [NUM_CHAN-1:0]    io_in_valid;
    logic [NUM_CHAN-1:0]    io_in_ready;
    logic [NUM_CHAN*3-1:0]  io_in_opcode;
    logic [NUM_CHAN*3-1:0]  io_in_param;
    logic [NUM_CHAN*8-1:0]  io_in_size;
    logic [NUM_CHAN*8-1:0]  io_in_source;
    logic [NUM_CHAN*64-1:0] io_in_address;
    logic [NUM_CHAN*64-1:0] io_in_data;
    logic [NUM_CHAN-1:0]    io_in_corrupt;
    logic [NUM_CHAN*9-1:0]  io_in_union;
    logic                   io_out_valid;
    logic                   io_out_ready;
    logic [serial_link_pkg::BEAT_W-1:0] io_out_bits;
    logic                   io_busy;

    modport master (
        output io_in_valid, io_in_opcode, io_in_param, io_in_size, io_in_source,
               io_in_address, io_in_data, io_in_corrupt, io_in_union, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_busy
    );

    modport slave (
        input  io_in_valid, io_in_opcode, io_in_param, io_in_size, io_in_source,
               io_in_address, io_in_data, io_in_corrupt, io_in_union, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_busy
    );
endinterface

// File: rtl/serial_link_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1 with wrap.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    always_comb begin : p_pick
        int               w_cand;
        logic [IDX_W-1:0] w_cand_idx;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = 0;
        w_cand_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand     = (int'(i_last_grant) + k) % N;
            w_cand_idx = IDX_W'(w_cand);
            if (!o_any && i_req[w_cand_idx]) begin
                o_any                = 1'b1;
                o_grant[w_cand_idx]  = 1'b1;
                o_grant_idx          = w_cand_idx;
            end
        end
    end

endmodule

// File: rtl/serial_link_tx_arbiter.sv
// Transmit-side arbiter: grants one TL channel round-robin, captures its message
// into a 192-bit frame and streams it to the link PHY FIFO as 6 beats, LSB beat first.
module serial_link_tx_arbiter
    import serial_link_pkg::*;
#(
    parameter int NUM_CHAN = 5
) (
    input logic                     clock,
    input logic                     reset,
    serial_link_tx_arbiter_if.slave bus
);

    localparam int         IDX_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    state_t                        r_state;
    state_t                        w_state_next;
    logic [2:0]                    r_beat;
    logic [IDX_W-1:0]              r_last_grant;
    logic [FRAME_W-1:0]            r_frame;
    logic [BEATS-1:0][BEAT_W-1:0]  w_beats;

    tl_msg_t          w_msg [NUM_CHAN];
    logic [NUM_CHAN-1:0] w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_any;
    logic                w_cap_opp;
    logic                w_capture;

    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_unpack
        assign w_msg[gi] = {bus.io_in_opcode[3*gi +: 3], bus.io_in_param[3*gi +: 3],
                            bus.io_in_size[8*gi +: 8], bus.io_in_source[8*gi +: 8],
                            bus.io_in_address[64*gi +: 64], bus.io_in_data[64*gi +: 64],
                            bus.io_in_corrupt[gi], bus.io_in_union[9*gi +: 9]};
    end

    rr_arbiter #(
        .N     (NUM_CHAN),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req        (bus.io_in_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A new frame may be captured while idle, or on the final beat's handshake so
    // back-to-back frames leave no bubble on the link.
    always_comb begin
        w_state_next = r_state;
        w_cap_opp    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cap_opp = 1'b1;
                if (w_any) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (r_beat == LAST_BEAT && bus.io_out_ready) begin
                    w_cap_opp    = 1'b1;
                    w_state_next = w_any ? SEND : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_capture       = w_cap_opp & w_any;
    assign bus.io_in_ready = w_capture ? w_grant : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_beat       <= '0;
            r_last_grant <= IDX_W'(NUM_CHAN - 1);
        end else if (w_capture) begin
            r_beat       <= '0;
            r_last_grant <= w_grant_idx;
        end else if (r_state == SEND && bus.io_out_ready) begin
            r_beat <= (r_beat == LAST_BEAT) ? 3'd0 : r_beat + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_capture) begin
            r_frame <= pack_frame(w_msg[w_grant_idx], 3'(w_grant_idx));
        end
    end

    assign w_beats          = r_frame;
    assign bus.io_out_valid = (r_state == SEND);
    assign bus.io_busy      = (r_state == SEND);
    assign bus.io_out_bits  = w_beats[r_beat];

endmodule
